// File: rtl/dco_freq_meter_if.sv
// dco_freq_meter_if: control, oscillator and result signals of the DCO frequency meter
interface dco_freq_meter_if #(
    parameter int CNT_W = 16
);
    logic             osc_in;
    logic             start;
    logic             cont;
    logic             busy;
    logic [CNT_W-1:0] count;
    logic             count_valid;
    logic             overflow;
    modport master (output osc_in, start, cont, input busy, count, count_valid, overflow);
    modport slave  (input osc_in, start, cont, output busy, count, count_valid, overflow);
endinterface

// File: rtl/dco_freq_meter.sv
// dco_freq_meter: counts synchronised osc_in rising edges over a GATE_CYCLES clk window
module dco_freq_meter #(
    parameter int GATE_CYCLES = 256,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    dco_freq_meter_if.slave bus
);
    localparam int GW = $clog2(GATE_CYCLES);
    typedef enum logic [1:0] {IDLE, GATE, DONE} state_t;
    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;
    logic                   rise;
    logic                   ovf_int;
    logic [GW-1:0]          gate_cnt;
    logic [CNT_W-1:0]       edge_cnt;
    assign rise = sync[SYNC_STAGES-1] & ~hist;
    always_ff @(posedge clk) begin
        if (reset) begin
            sync            <= '0;
            hist            <= 1'b0;
            state           <= IDLE;
            gate_cnt        <= '0;
            edge_cnt        <= '0;
            ovf_int         <= 1'b0;
            bus.busy        <= 1'b0;
            bus.count       <= '0;
            bus.count_valid <= 1'b0;
            bus.overflow    <= 1'b0;
        end else begin
            // the input path keeps running across windows so no false edge appears at a window start
            sync            <= {sync[SYNC_STAGES-2:0], bus.osc_in};
            hist            <= sync[SYNC_STAGES-1];
            bus.count_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start | bus.cont) begin
                        state    <= GATE;
                        bus.busy <= 1'b1;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        ovf_int  <= 1'b0;
                    end
                end
                GATE: begin
                    gate_cnt <= gate_cnt + 1'b1;
                    if (rise) begin
                        if (&edge_cnt) ovf_int <= 1'b1;
                        else edge_cnt <= edge_cnt + 1'b1;
                    end
                    if (gate_cnt == GW'(GATE_CYCLES - 1)) state <= DONE;
                end
                DONE: begin
                    bus.count       <= edge_cnt;
                    bus.overflow    <= ovf_int;
                    bus.count_valid <= 1'b1;
                    state           <= bus.cont ? GATE : IDLE;
                    bus.busy        <= bus.cont;
                    gate_cnt        <= '0;
                    edge_cnt        <= '0;
                    ovf_int         <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dco_freq_meter.sv
// tb_dco_freq_meter: directed and random windows checked against a sampled-waveform edge model
module tb_dco_freq_meter;
    localparam int G    = 256;
    localparam int S    = 2;
    localparam int MAXC = 16384;
    logic clk;
    logic reset;
    logic osc;
    logic start;
    logic cont;
    int   half;
    logic lvl;
    int   ph;
    int   cyc;
    int   errors;
    int   checks;
    int   n;
    logic sarr [0:MAXC-1];
    dco_freq_meter_if #(.CNT_W(16)) a ();
    dco_freq_meter_if #(.CNT_W(4))  b ();
    assign a.osc_in = osc;
    assign b.osc_in = osc;
    assign a.start  = start;
    assign b.start  = start;
    assign a.cont   = cont;
    assign b.cont   = cont;
    dco_freq_meter #(.GATE_CYCLES(G), .CNT_W(16), .SYNC_STAGES(S)) dut_a (.clk(clk), .reset(reset), .bus(a));
    dco_freq_meter #(.GATE_CYCLES(G), .CNT_W(4),  .SYNC_STAGES(S)) dut_b (.clk(clk), .reset(reset), .bus(b));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc + 1 < MAXC) sarr[cyc+1] <= osc;
    end
    // square wave with half-period 'half' clk cycles, or a static level when half is 0
    always @(negedge clk) begin
        if (half == 0) osc <= lvl;
        else if (ph >= half - 1) begin
            ph  <= 0;
            osc <= ~osc;
        end else ph <= ph + 1;
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    // rising transitions of osc as seen at each window edge, after the synchroniser delay
    function automatic int edges(input int ns);
        int e = 0;
        for (int k = ns + 1; k <= ns + G; k++)
            if (sarr[k-S] === 1'b1 && sarr[k-S-1] === 1'b0) e++;
        return e;
    endfunction
    task automatic pulse_start(output int ns);
        start = 1'b1;
        ns = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_open", {31'b0, a.busy}, 1);
    endtask
    task automatic check_result(input int ns, input logic exp_busy);
        int t = 0;
        int e;
        while (a.count_valid !== 1'b1 && t < 2 * G) begin
            @(negedge clk);
            t++;
        end
        e = edges(ns);
        chk("valid", {31'b0, a.count_valid}, 1);
        chk("latency", cyc, ns + G + 1);
        chk("count16", {16'b0, a.count}, (e > 65535) ? 65535 : e);
        chk("ovf16", {31'b0, a.overflow}, (e > 65535) ? 1 : 0);
        chk("valid4", {31'b0, b.count_valid}, 1);
        chk("count4", {28'b0, b.count}, (e > 15) ? 15 : e);
        chk("ovf4", {31'b0, b.overflow}, (e > 15) ? 1 : 0);
        chk("busy_post", {31'b0, a.busy}, {31'b0, exp_busy});
        @(negedge clk);
        chk("pulse_len", {31'b0, a.count_valid}, 0);
        chk("count_hold", {16'b0, a.count}, (e > 65535) ? 65535 : e);
    endtask
    task automatic no_valid(input int len);
        int seen = 0;
        repeat (len) begin
            @(negedge clk);
            if (a.count_valid !== 1'b0) seen++;
        end
        chk("no_valid", seen, 0);
    endtask
    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        ph     = 0;
        half   = 0;
        lvl    = 1'b0;
        osc    = 1'b0;
        start  = 1'b0;
        cont   = 1'b0;
        reset  = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, a.busy}, 0);
        chk("rst_count", {16'b0, a.count}, 0);
        chk("rst_valid", {31'b0, a.count_valid}, 0);
        chk("rst_ovf", {31'b0, a.overflow}, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        half = 4;
        repeat (20) @(negedge clk);
        pulse_start(n);
        check_result(n, 1'b0);
        half = 0;
        lvl  = 1'b0;
        repeat (20) @(negedge clk);
        pulse_start(n);
        check_result(n, 1'b0);
        lvl = 1'b1;
        repeat (20) @(negedge clk);
        pulse_start(n);
        check_result(n, 1'b0);
        half = 2;
        repeat (10) @(negedge clk);
        pulse_start(n);
        check_result(n, 1'b0);
        half = 0;
        lvl  = 1'b0;
        repeat (10) @(negedge clk);
        pulse_start(n);
        check_result(n, 1'b0);
        half = 4;
        repeat (10) @(negedge clk);
        cont = 1'b1;
        n = cyc + 1;
        for (int w = 0; w < 4; w++) begin
            check_result(n, (w < 3) ? 1'b1 : 1'b0);
            n = n + G + 1;
            half = (w == 0) ? 8 : int'($urandom_range(2, 12));
            if (w == 2) begin
                repeat (100) @(negedge clk);
                cont = 1'b0;
            end
        end
        no_valid(300);
        half = 5;
        pulse_start(n);
        repeat (120) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_result(n, 1'b0);
        no_valid(300);
        pulse_start(n);
        repeat (99) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", {31'b0, a.busy}, 0);
        chk("abort_count", {16'b0, a.count}, 0);
        chk("abort_ovf", {31'b0, a.overflow}, 0);
        chk("abort_valid", {31'b0, a.count_valid}, 0);
        no_valid(300);
        for (int r = 0; r < 6; r++) begin
            half = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(2, 30));
            lvl  = 1'($urandom_range(0, 1));
            repeat ($urandom_range(5, 40)) @(negedge clk);
            pulse_start(n);
            check_result(n, 1'b0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
